// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the data-memory access unit: dm_ctrl width codes,
// sequencer state encoding and the alignment rule.
package mem_access_unit_pkg;

    localparam logic [2:0] dm_word              = 3'b000;
    localparam logic [2:0] dm_halfword          = 3'b001;
    localparam logic [2:0] dm_halfword_unsigned = 3'b010;
    localparam logic [2:0] dm_byte              = 3'b011;
    localparam logic [2:0] dm_byte_unsigned     = 3'b100;

    typedef enum logic [1:0] {
        MAU_IDLE = 2'b00,
        MAU_BUSY = 2'b01,
        MAU_DONE = 2'b10
    } mau_state_t;

    // Undefined width codes fall back to word alignment.
    function automatic logic is_misaligned(input logic [2:0] dm_ctrl, input logic [1:0] byte_off);
        logic mis;
        case (dm_ctrl)
            dm_halfword, dm_halfword_unsigned: mis = byte_off[0];
            dm_byte, dm_byte_unsigned:         mis = 1'b0;
            default:                           mis = (byte_off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load-data extractor: selects the addressed half/byte lane of a bus word and
// sign- or zero-extends it according to the width code.
module load_align
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]  dm_ctrl,
    input  logic [1:0]  byte_off,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    always_comb begin
        half_sel = byte_off[1] ? word[31:16] : word[15:0];
        case (byte_off)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
    end

    always_comb begin
        case (dm_ctrl)
            dm_halfword:          data = {{16{half_sel[15]}}, half_sel};
            dm_halfword_unsigned: data = {16'h0000, half_sel};
            dm_byte:              data = {{24{byte_sel[7]}}, byte_sel};
            dm_byte_unsigned:     data = {24'h000000, byte_sel};
            default:              data = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access sequencer: turns a MEM-stage request into a held bus cycle,
// stalls the pipeline until ack or timeout, and returns aligned load data.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter int unsigned CNT_W       = 5
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [2:0]  dm_ctrl_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        bus_en,
    output logic [3:0]  bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        stall_out,
    output logic [31:0] rdata_out,
    output logic        done_out,
    output logic        misalign_out,
    output logic        timeout_out
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    mau_state_t       state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       ctrl_r;
    logic [1:0]       off_r;
    logic             we_r;
    logic [3:0]       we_mask_r;
    logic [31:0]      addr_r, wdata_r, rdata_r;
    logic             misalign_r, timeout_r;

    logic             req, misaligned, accept, expire;
    logic [3:0]       be;
    logic [31:0]      lane;
    logic [31:0]      aligned;

    assign req        = mem_read_in | mem_write_in;
    assign misaligned = is_misaligned(dm_ctrl_in, addr_in[1:0]);

    always_comb begin
        be   = 4'b1111;
        lane = wdata_in;
        case (dm_ctrl_in)
            dm_halfword, dm_halfword_unsigned: begin
                be   = addr_in[1] ? 4'b1100 : 4'b0011;
                lane = {2{wdata_in[15:0]}};
            end
            dm_byte, dm_byte_unsigned: begin
                be   = 4'b0001 << addr_in[1:0];
                lane = {4{wdata_in[7:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= MAU_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        stall_out = 1'b0;
        accept    = 1'b0;
        expire    = 1'b0;
        case (state)
            MAU_IDLE: begin
                if (req && !misaligned) begin
                    accept    = 1'b1;
                    stall_out = 1'b1;
                    state_nx  = MAU_BUSY;
                end
            end
            MAU_BUSY: begin
                stall_out = 1'b1;
                if (bus_ack) begin
                    state_nx = MAU_DONE;
                end else if (cnt == CNT_LAST) begin
                    expire   = 1'b1;
                    state_nx = MAU_DONE;
                end
            end
            MAU_DONE: state_nx = MAU_IDLE;
            default:  state_nx = MAU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt        <= '0;
            ctrl_r     <= '0;
            off_r      <= '0;
            we_r       <= 1'b0;
            we_mask_r  <= '0;
            addr_r     <= '0;
            wdata_r    <= '0;
            rdata_r    <= '0;
            misalign_r <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            misalign_r <= (state == MAU_IDLE) && req && misaligned;
            timeout_r  <= expire;
            cnt        <= (state == MAU_BUSY) ? cnt + CNT_W'(1) : '0;
            if (accept) begin
                ctrl_r    <= dm_ctrl_in;
                off_r     <= addr_in[1:0];
                we_r      <= mem_write_in;
                we_mask_r <= mem_write_in ? be : 4'b0000;
                addr_r    <= {addr_in[31:2], 2'b00};
                wdata_r   <= lane;
            end
            if (state == MAU_BUSY) begin
                if (bus_ack) begin
                    if (!we_r) rdata_r <= aligned;
                end else if (expire) begin
                    rdata_r <= '0;
                end
            end
        end
    end

    load_align u_load_align (
        .dm_ctrl  (ctrl_r),
        .byte_off (off_r),
        .word     (bus_rdata),
        .data     (aligned)
    );

    // Bus strobes derive from the state register so an async reset drops them at once.
    assign bus_en       = (state == MAU_BUSY);
    assign bus_we       = bus_en ? we_mask_r : 4'b0000;
    assign bus_addr     = addr_r;
    assign bus_wdata    = wdata_r;
    assign done_out     = (state == MAU_DONE);
    assign misalign_out = misalign_r;
    assign timeout_out  = timeout_r;
    assign rdata_out    = rdata_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, randomized
// accesses against a lane-arithmetic reference model, and a mid-access reset.
module tb_mem_access_unit;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        mem_read_in = 1'b0, mem_write_in = 1'b0;
    logic [2:0]  dm_ctrl_in = '0;
    logic [31:0] addr_in = '0, wdata_in = '0, bus_rdata = '0;
    logic        bus_ack = 1'b0;
    logic        bus_en, stall_out, done_out, misalign_out, timeout_out;
    logic [3:0]  bus_we;
    logic [31:0] bus_addr, bus_wdata, rdata_out;

    mem_access_unit #(.TIMEOUT_CYC(TO), .CNT_W(5)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .mem_read_in  (mem_read_in),
        .mem_write_in (mem_write_in),
        .dm_ctrl_in   (dm_ctrl_in),
        .addr_in      (addr_in),
        .wdata_in     (wdata_in),
        .bus_rdata    (bus_rdata),
        .bus_ack      (bus_ack),
        .bus_en       (bus_en),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .stall_out    (stall_out),
        .rdata_out    (rdata_out),
        .done_out     (done_out),
        .misalign_out (misalign_out),
        .timeout_out  (timeout_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  ctrl;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          wait_n;
        logic        mis;
        logic [3:0]  we;
        logic [31:0] ba;
        logic [31:0] wd;
        logic        chk_wd;
        logic [31:0] rdout;
        logic        hold;
        logic        to;
    } vec_t;

    int          n_vec = 0;
    int          n_bad = 0;
    string       cur = "reset";
    logic [31:0] held_rd = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s/%s: got 0x%08h want 0x%08h", cur, name, act, exp);
        end
    endtask

    // Width codes: 0 w, 1 h, 2 hu, 3 b, 4 bu, others behave as word.
    function automatic void model(input logic wr, input logic [2:0] ctrl, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] rdata,
                                  output logic mis, output logic [3:0] we,
                                  output logic [31:0] wd, output logic [31:0] rd);
        int unsigned size, lane;
        logic        sgn;
        logic [31:0] mask;
        case (ctrl)
            3'd1:    begin size = 2; sgn = 1'b1; end
            3'd2:    begin size = 2; sgn = 1'b0; end
            3'd3:    begin size = 1; sgn = 1'b1; end
            3'd4:    begin size = 1; sgn = 1'b0; end
            default: begin size = 4; sgn = 1'b0; end
        endcase
        lane = addr % 4;
        mis  = (addr % size) != 0;
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        we   = wr ? 4'(((1 << size) - 1) << lane) : 4'b0000;
        wd   = (wdata & mask) * (32'hFFFF_FFFF / mask);
        rd   = (rdata >> (8 * lane)) & mask;
        if (sgn && rd > (mask >> 1)) rd = rd | ~mask;
    endfunction

    task automatic apply(input vec_t v);
        int          n;
        int          exp_n;
        logic [31:0] exp_rd;
        mem_read_in  = v.rd;
        mem_write_in = v.wr;
        dm_ctrl_in   = v.ctrl;
        addr_in      = v.addr;
        wdata_in     = v.wdata;
        #1;
        check("stall_req", 32'(stall_out), 32'(!v.mis));
        @(posedge clk); #1;
        mem_read_in  = 1'b0;
        mem_write_in = 1'b0;
        addr_in      = $urandom;
        wdata_in     = $urandom;
        if (v.mis) begin
            check("misalign", 32'(misalign_out), 32'd1);
            check("mis_bus_en", 32'(bus_en), 32'd0);
            check("mis_stall", 32'(stall_out), 32'd0);
            @(posedge clk); #1;
            check("misalign_drop", 32'(misalign_out), 32'd0);
            check("mis_bus_en2", 32'(bus_en), 32'd0);
            return;
        end
        check("bus_en", 32'(bus_en), 32'd1);
        check("stall_busy", 32'(stall_out), 32'd1);
        check("bus_we", 32'(bus_we), 32'(v.we));
        check("bus_addr", bus_addr, v.ba);
        if (v.chk_wd) check("bus_wdata", bus_wdata, v.wd);
        n = 0;
        do begin
            bus_ack   = (n == v.wait_n);
            bus_rdata = v.rdata;
            @(posedge clk); #1;
            n++;
        end while (!done_out && n < 40);
        bus_ack   = 1'b0;
        bus_rdata = $urandom;
        exp_n  = (v.wait_n < int'(TO)) ? v.wait_n + 1 : int'(TO);
        exp_rd = v.hold ? held_rd : v.rdout;
        held_rd = exp_rd;
        check("busy_cycles", 32'(n), 32'(exp_n));
        check("done", 32'(done_out), 32'd1);
        check("stall_done", 32'(stall_out), 32'd0);
        check("bus_en_done", 32'(bus_en), 32'd0);
        check("bus_we_done", 32'(bus_we), 32'd0);
        check("timeout", 32'(timeout_out), 32'(v.to));
        check("rdata", rdata_out, exp_rd);
        @(posedge clk); #1;
        check("done_drop", 32'(done_out), 32'd0);
        check("timeout_drop", 32'(timeout_out), 32'd0);
        check("rdata_hold", rdata_out, held_rd);
    endtask

    vec_t tbl[15];
    vec_t rv;

    initial begin
        // rd wr ctrl addr wdata rdata wait mis we ba wd chk_wd rdout hold to
        tbl[0]  = '{0, 1, 3'd0, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 4'b1111, 32'h100, 32'hDEADBEEF, 1, 32'h0, 1, 0};
        tbl[1]  = '{1, 0, 3'd3, 32'h203, 32'h0, 32'h80112233, 0, 0, 4'b0000, 32'h200, 32'h0, 0, 32'hFFFFFF80, 0, 0};
        tbl[2]  = '{1, 0, 3'd4, 32'h203, 32'h0, 32'h80112233, 0, 0, 4'b0000, 32'h200, 32'h0, 0, 32'h00000080, 0, 0};
        tbl[3]  = '{1, 0, 3'd1, 32'h202, 32'h0, 32'h80112233, 0, 0, 4'b0000, 32'h200, 32'h0, 0, 32'hFFFF8011, 0, 0};
        tbl[4]  = '{1, 0, 3'd2, 32'h202, 32'h0, 32'h80112233, 1, 0, 4'b0000, 32'h200, 32'h0, 0, 32'h00008011, 0, 0};
        tbl[5]  = '{0, 1, 3'd3, 32'h0E, 32'h000000A5, 32'h0, 0, 0, 4'b0100, 32'h0C, 32'hA5A5A5A5, 1, 32'h0, 1, 0};
        tbl[6]  = '{1, 0, 3'd0, 32'h102, 32'h0, 32'h0, 0, 1, 4'b0000, 32'h0, 32'h0, 0, 32'h0, 1, 0};
        tbl[7]  = '{0, 1, 3'd1, 32'h101, 32'h1234, 32'h0, 0, 1, 4'b0000, 32'h0, 32'h0, 0, 32'h0, 1, 0};
        tbl[8]  = '{1, 1, 3'd1, 32'h002, 32'h1234ABCD, 32'h0, 0, 0, 4'b1100, 32'h0, 32'hABCDABCD, 1, 32'h0, 1, 0};
        tbl[9]  = '{1, 0, 3'd1, 32'h200, 32'h0, 32'h1234F00D, 2, 0, 4'b0000, 32'h200, 32'h0, 0, 32'hFFFFF00D, 0, 0};
        tbl[10] = '{1, 0, 3'd6, 32'h104, 32'h0, 32'h80000001, 1, 0, 4'b0000, 32'h104, 32'h0, 0, 32'h80000001, 0, 0};
        tbl[11] = '{1, 0, 3'd7, 32'h105, 32'h0, 32'h0, 0, 1, 4'b0000, 32'h0, 32'h0, 0, 32'h0, 1, 0};
        tbl[12] = '{1, 0, 3'd0, 32'h10, 32'h0, 32'hCAFEF00D, 15, 0, 4'b0000, 32'h10, 32'h0, 0, 32'hCAFEF00D, 0, 0};
        tbl[13] = '{1, 0, 3'd0, 32'h20, 32'h0, 32'h11111111, 99, 0, 4'b0000, 32'h20, 32'h0, 0, 32'h0, 0, 1};
        tbl[14] = '{0, 1, 3'd4, 32'h33, 32'hFFFFFF5A, 32'h0, 3, 0, 4'b1000, 32'h30, 32'h5A5A5A5A, 1, 32'h0, 1, 0};

        #1;
        check("rst_bus_en", 32'(bus_en), 32'd0);
        check("rst_bus_we", 32'(bus_we), 32'd0);
        check("rst_stall", 32'(stall_out), 32'd0);
        check("rst_done", 32'(done_out), 32'd0);
        check("rst_misalign", 32'(misalign_out), 32'd0);
        check("rst_timeout", 32'(timeout_out), 32'd0);
        check("rst_rdata", rdata_out, 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) begin
            cur = $sformatf("tbl%0d", i);
            apply(tbl[i]);
        end

        for (int i = 0; i < 60; i++) begin
            cur = $sformatf("rnd%0d", i);
            rv.rd    = 1'($urandom_range(0, 1));
            rv.wr    = 1'($urandom_range(0, 1));
            if (!rv.rd && !rv.wr) rv.rd = 1'b1;
            rv.ctrl  = 3'($urandom_range(0, 7));
            rv.addr  = $urandom;
            rv.wdata = $urandom;
            rv.rdata = $urandom;
            rv.wait_n = ($urandom_range(0, 9) == 0) ? 30 : int'($urandom_range(0, 3));
            model(rv.wr, rv.ctrl, rv.addr, rv.wdata, rv.rdata, rv.mis, rv.we, rv.wd, rv.rdout);
            rv.ba     = rv.addr & 32'hFFFF_FFFC;
            rv.chk_wd = rv.wr;
            rv.to     = (rv.wait_n >= int'(TO));
            rv.hold   = rv.wr && !rv.to;
            if (rv.to) rv.rdout = '0;
            apply(rv);
        end

        cur = "reset_mid";
        mem_read_in = 1'b1;
        dm_ctrl_in  = 3'd0;
        addr_in     = 32'h300;
        @(posedge clk); #1;
        mem_read_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("busy_before_rst", 32'(bus_en), 32'd1);
        #1 rstn = 1'b0;
        #1;
        check("rst_bus_en", 32'(bus_en), 32'd0);
        check("rst_stall", 32'(stall_out), 32'd0);
        check("rst_done", 32'(done_out), 32'd0);
        repeat (2) begin
            @(posedge clk); #1;
            check("rst_hold_done", 32'(done_out), 32'd0);
        end
        #2 rstn = 1'b1;
        @(posedge clk); #1;
        check("post_rst_done", 32'(done_out), 32'd0);
        check("post_rst_rdata", rdata_out, 32'd0);
        held_rd = '0;
        rv = '{1, 0, 3'd0, 32'h304, 32'h0, 32'h13579BDF, 1, 0, 4'b0000, 32'h304, 32'h0, 0, 32'h13579BDF, 0, 0};
        apply(rv);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
